// File: rtl/seq_digit_comparator_if.sv
// Operand/result handshake bundle for seq_digit_comparator.
// The consumer-side block uses the slave modport; the stimulus side uses master.
interface seq_digit_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [CW-1:0]    cycles;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, lt, eq, gt, cycles
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, lt, eq, gt, cycles
  );
endinterface

// File: rtl/seq_digit_comparator.sv
// Multi-cycle magnitude compare: DIGIT bits per clock, MSB digit first, with
// optional early exit at the first differing digit.
module seq_digit_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1,
  localparam int NDIG      = WIDTH / DIGIT,
  localparam int CW        = $clog2(NDIG + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_digit_comparator_if.slave bus
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("seq_digit_comparator: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             diff_seen;
  logic             last_dig;
  logic             finish;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    // Operands shift left each RUN cycle, so the current digit is always on top.
    dig_a       = a_q[WIDTH-1 -: DIGIT];
    dig_b       = b_q[WIDTH-1 -: DIGIT];
    diff_seen   = lt_q | gt_q;
    last_dig    = (cnt_q == CW'(NDIG - 1));
    finish      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d = bus.a;
          b_d = bus.b;
          // Offset-binary: flipping both sign bits turns a signed compare unsigned.
          if (bus.signed_mode) begin
            a_d[WIDTH-1] = ~bus.a[WIDTH-1];
            b_d[WIDTH-1] = ~bus.b[WIDTH-1];
          end
          lt_d       = 1'b0;
          eq_d       = 1'b0;
          gt_d       = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (!diff_seen && (dig_a != dig_b)) begin
          lt_d = (dig_a < dig_b);
          gt_d = (dig_a > dig_b);
          if (EARLY_EXIT != 0) finish = 1'b1;
        end
        if (last_dig) begin
          finish = 1'b1;
          if (!diff_seen && (dig_a == dig_b)) eq_d = 1'b1;
        end
        if (finish) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          cycles_d    = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.cycles    = cycles_q;

  a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q |-> $onehot({lt_q, eq_q, gt_q}));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready_q && out_valid_q));

endmodule

// File: tb/tb_seq_digit_comparator.sv
// Drives four builds (D4/early, D4/full-scan, D1, D16) with shared operands and
// checks each result against a plain-arithmetic reference.
module tb_seq_digit_comparator;
  localparam int W = 16;
  localparam int DIGS [4] = '{4, 4, 1, 16};
  localparam int EES  [4] = '{1, 0, 1, 1};

  localparam logic [15:0] TA [7] = '{16'h1234, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h12A4, 16'h12B0};
  localparam logic [15:0] TB [7] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h12B4, 16'h12A9};
  localparam logic        TS [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [2:0]  TF [7] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b001, 3'b100, 3'b001};
  localparam int          TC [7] = '{4, 1, 1, 1, 1, 3, 3};

  typedef struct { logic lt; logic eq; logic gt; int cyc; int lat; } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]   iv = 4'h0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic sm_in = 1'b0;
  logic out_ready = 1'b1;
  bit   out_rand = 1'b0;

  logic [3:0] ir, ov, rlt, req, rgt;
  logic [4:0] rcyc [4];

  int cyc = 0;
  int acc_c [4];
  int acc_n [4];
  int lat_r [4];
  bit seen [4];
  res_t q0[$], q1[$], q2[$], q3[$];
  int n_tot = 0, n_bad = 0;

  seq_digit_comparator_if #(.WIDTH(W), .DIGIT(4))  if0 ();
  seq_digit_comparator_if #(.WIDTH(W), .DIGIT(4))  if1 ();
  seq_digit_comparator_if #(.WIDTH(W), .DIGIT(1))  if2 ();
  seq_digit_comparator_if #(.WIDTH(W), .DIGIT(16)) if3 ();

  seq_digit_comparator #(.WIDTH(W), .DIGIT(4),  .EARLY_EXIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_digit_comparator #(.WIDTH(W), .DIGIT(4),  .EARLY_EXIT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_digit_comparator #(.WIDTH(W), .DIGIT(1),  .EARLY_EXIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  seq_digit_comparator #(.WIDTH(W), .DIGIT(16), .EARLY_EXIT(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.in_valid = iv[0]; assign if0.a = a_in; assign if0.b = b_in; assign if0.signed_mode = sm_in; assign if0.out_ready = out_ready;
  assign if1.in_valid = iv[1]; assign if1.a = a_in; assign if1.b = b_in; assign if1.signed_mode = sm_in; assign if1.out_ready = out_ready;
  assign if2.in_valid = iv[2]; assign if2.a = a_in; assign if2.b = b_in; assign if2.signed_mode = sm_in; assign if2.out_ready = out_ready;
  assign if3.in_valid = iv[3]; assign if3.a = a_in; assign if3.b = b_in; assign if3.signed_mode = sm_in; assign if3.out_ready = out_ready;

  assign ir  = {if3.in_ready,  if2.in_ready,  if1.in_ready,  if0.in_ready};
  assign ov  = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign rlt = {if3.lt, if2.lt, if1.lt, if0.lt};
  assign req = {if3.eq, if2.eq, if1.eq, if0.eq};
  assign rgt = {if3.gt, if2.gt, if1.gt, if0.gt};
  assign rcyc[0] = 5'(if0.cycles);
  assign rcyc[1] = 5'(if1.cycles);
  assign rcyc[2] = 5'(if2.cycles);
  assign rcyc[3] = 5'(if3.cycles);

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: latency is edges from accept to first out_valid; results logged on handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      res_t r;
      int   l;
      l = seen[i] ? lat_r[i] : (cyc - acc_c[i] - 1);
      if (ov[i] && !seen[i]) begin
        lat_r[i] <= l;
        seen[i]  <= 1'b1;
      end
      if (ov[i] && out_ready) begin
        r.lt = rlt[i]; r.eq = req[i]; r.gt = rgt[i]; r.cyc = int'(rcyc[i]); r.lat = l;
        case (i)
          0: q0.push_back(r);
          1: q1.push_back(r);
          2: q2.push_back(r);
          default: q3.push_back(r);
        endcase
        seen[i] <= 1'b0;
      end
      if (iv[i] && ir[i]) begin
        acc_c[i] <= cyc;
        acc_n[i] <= acc_n[i] + 1;
        seen[i]  <= 1'b0;
      end
    end
  end

  function automatic int q_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic res_t pop_res(input int i);
    res_t r;
    r = '{lt: 1'b0, eq: 1'b0, gt: 1'b0, cyc: -1, lat: -1};
    case (i)
      0: if (q0.size() > 0) r = q0.pop_front();
      1: if (q1.size() > 0) r = q1.pop_front();
      2: if (q2.size() > 0) r = q2.pop_front();
      default: if (q3.size() > 0) r = q3.pop_front();
    endcase
    return r;
  endfunction

  // Reference: integer compare for the verdict, digit scan for the cycle count.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                 input int dig, input int ee);
    res_t r;
    int va, vb, nd, first, sh, m;
    if (sm) begin va = $signed(a); vb = $signed(b); end
    else    begin va = a;          vb = b;          end
    r.lt = (va < vb); r.eq = (va == vb); r.gt = (va > vb);
    nd = 16 / dig; first = -1; m = (1 << dig) - 1;
    for (int k = 0; k < nd; k++) begin
      sh = 16 - dig * (k + 1);
      if (first < 0 && (((a >> sh) & m) != ((b >> sh) & m))) first = k;
    end
    r.cyc = (ee != 0 && first >= 0) ? first + 1 : nd;
    r.lat = r.cyc;
    return r;
  endfunction

  task automatic send_start(input logic [15:0] a, input logic [15:0] b, input logic sm);
    a_in = a; b_in = b; sm_in = sm; iv = 4'hF;
  endtask

  task automatic wait_accept(input string tag);
    logic [3:0] acc;
    for (int t = 0; t < 500 && iv != 4'h0; t++) begin
      @(negedge clk); acc = iv & ir;
      @(posedge clk); #1;
      iv = iv & ~acc;
      if (out_rand) out_ready = 1'($urandom_range(0, 1));
    end
    if (iv != 4'h0) begin
      n_tot++; n_bad++;
      $display("FAIL %s accept_timeout: pending=%b want 0000", tag, iv);
      iv = 4'h0;
    end
  endtask

  task automatic wait_results(input int n, input string tag);
    int t;
    t = 0;
    while (!(q0.size() >= n && q1.size() >= n && q2.size() >= n && q3.size() >= n) && t < 500) begin
      @(posedge clk); #1;
      if (out_rand) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 500) begin
      n_tot++; n_bad++;
      $display("FAIL %s result_timeout: got %0d/%0d/%0d/%0d results want %0d each",
               tag, q0.size(), q1.size(), q2.size(), q3.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || rlt[i] !== 1'b0 || req[i] !== 1'b0 ||
          rgt[i] !== 1'b0 || rcyc[i] !== 5'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got in_ready=%b out_valid=%b lt=%b eq=%b gt=%b cycles=%0d want 1 0 0 0 0 0",
                 i, ir[i], ov[i], rlt[i], req[i], rgt[i], rcyc[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    res_t r, e;
    out_rand = 1'b0; out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      send_start(TA[v], TB[v], TS[v]);
      wait_accept("directed");
      wait_results(1, "directed");
      for (int i = 0; i < 4; i++) begin
        r = pop_res(i);
        e = model(TA[v], TB[v], TS[v], DIGS[i], EES[i]);
        n_tot++;
        if (r.lt !== e.lt || r.eq !== e.eq || r.gt !== e.gt || r.cyc != e.cyc || r.lat != e.lat) begin
          n_bad++;
          $display("FAIL directed[%0d] dut%0d: got lt=%b eq=%b gt=%b cycles=%0d lat=%0d want lt=%b eq=%b gt=%b cycles=%0d lat=%0d",
                   v, i, r.lt, r.eq, r.gt, r.cyc, r.lat, e.lt, e.eq, e.gt, e.cyc, e.lat);
        end
        if (i == 0) begin
          n_tot++;
          if ({r.lt, r.eq, r.gt} !== TF[v] || r.cyc != TC[v]) begin
            n_bad++;
            $display("FAIL directed_const[%0d]: got ltEqGt=%b cycles=%0d want %b cycles=%0d",
                     v, {r.lt, r.eq, r.gt}, r.cyc, TF[v], TC[v]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t r, e;
    int t, r_edge;
    logic [15:0] xa [2];
    logic [15:0] xb [2];
    xa[0] = 16'h12A4; xb[0] = 16'h12B4; xa[1] = 16'h0005; xb[1] = 16'h0003;
    out_rand = 1'b0; out_ready = 1'b0;
    send_start(xa[0], xb[0], 1'b0);
    wait_accept("bp");
    t = 0;
    while (ov[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_tot++;
    if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_wait: out_valid=%b want 1", ov[0]); end
    // Competing request while the result is being held.
    a_in = xa[1]; b_in = xb[1]; sm_in = 1'b0; iv = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tot++;
      if (ov[0] !== 1'b1 || rlt[0] !== 1'b1 || req[0] !== 1'b0 || rgt[0] !== 1'b0 ||
          rcyc[0] !== 5'd3 || ir[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b lt=%b eq=%b gt=%b cycles=%0d in_ready=%b want 1 1 0 0 3 0",
                 k, ov[0], rlt[0], req[0], rgt[0], rcyc[0], ir[0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1; r_edge = cyc;
    wait_accept("bp_pending");
    n_tot++;
    if (acc_c[0] != r_edge + 1) begin
      n_bad++;
      $display("FAIL bp_reaccept: accept offset=%0d want 1", acc_c[0] - r_edge);
    end
    wait_results(2, "bp");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        r = pop_res(i);
        e = model(xa[j], xb[j], 1'b0, DIGS[i], EES[i]);
        n_tot++;
        if (r.lt !== e.lt || r.eq !== e.eq || r.gt !== e.gt || r.cyc != e.cyc || r.lat != e.lat) begin
          n_bad++;
          $display("FAIL bp_result[%0d] dut%0d: got lt=%b eq=%b gt=%b cycles=%0d lat=%0d want lt=%b eq=%b gt=%b cycles=%0d lat=%0d",
                   j, i, r.lt, r.eq, r.gt, r.cyc, r.lat, e.lt, e.eq, e.gt, e.cyc, e.lat);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    res_t r, e;
    out_rand = 1'b0; out_ready = 1'b1;
    send_start(16'h1234, 16'h1234, 1'b0);
    wait_accept("rst_run");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || rlt[i] !== 1'b0 || req[i] !== 1'b0 ||
          rgt[i] !== 1'b0 || rcyc[i] !== 5'd0) begin
        n_bad++;
        $display("FAIL rst_run_state dut%0d: got in_ready=%b out_valid=%b lt=%b eq=%b gt=%b cycles=%0d want 1 0 0 0 0 0",
                 i, ir[i], ov[i], rlt[i], req[i], rgt[i], rcyc[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_tot++;
    if (q_size(0) + q_size(1) + q_size(2) + q_size(3) != 0 || ov !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_run_stale: got results=%0d out_valid=%b want 0 0000",
               q_size(0) + q_size(1) + q_size(2) + q_size(3), ov);
    end
    send_start(16'h0001, 16'h0002, 1'b0);
    wait_accept("rst_after");
    wait_results(1, "rst_after");
    for (int i = 0; i < 4; i++) begin
      r = pop_res(i);
      e = model(16'h0001, 16'h0002, 1'b0, DIGS[i], EES[i]);
      n_tot++;
      if (r.lt !== e.lt || r.eq !== e.eq || r.gt !== e.gt || r.cyc != e.cyc || r.lat != e.lat ||
          (i == 0 && (r.lt !== 1'b1 || r.cyc != 4))) begin
        n_bad++;
        $display("FAIL rst_after dut%0d: got lt=%b eq=%b gt=%b cycles=%0d lat=%0d want lt=%b eq=%b gt=%b cycles=%0d lat=%0d",
                 i, r.lt, r.eq, r.gt, r.cyc, r.lat, e.lt, e.eq, e.gt, e.cyc, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    int base [4];
    logic [15:0] a, b;
    logic sm;
    for (int i = 0; i < 4; i++) base[i] = acc_n[i];
    out_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 16'($urandom);
        2: b = a ^ (16'h1 << $urandom_range(0, 15));
        default: b = a ^ (16'h8000 >> $urandom_range(0, 3));
      endcase
      sm = 1'($urandom_range(0, 1));
      send_start(a, b, sm);
      wait_accept("b2b");
      wait_results(1, "b2b");
      for (int i = 0; i < 4; i++) begin
        r = pop_res(i);
        e = model(a, b, sm, DIGS[i], EES[i]);
        n_tot++;
        if (r.lt !== e.lt || r.eq !== e.eq || r.gt !== e.gt || r.cyc != e.cyc || r.lat != e.lat) begin
          n_bad++;
          $display("FAIL b2b[%0d] dut%0d a=%h b=%h s=%b: got lt=%b eq=%b gt=%b cycles=%0d lat=%0d want lt=%b eq=%b gt=%b cycles=%0d lat=%0d",
                   n, i, a, b, sm, r.lt, r.eq, r.gt, r.cyc, r.lat, e.lt, e.eq, e.gt, e.cyc, e.lat);
        end
      end
    end
    out_rand = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (acc_n[i] - base[i] != 20 || q_size(i) != 0) begin
        n_bad++;
        $display("FAIL b2b_count dut%0d: got accepts=%0d leftover=%0d want 20 0",
                 i, acc_n[i] - base[i], q_size(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
